// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b byte-banked memory controller.
package lc3b_mem_pkg;

    localparam int   ADDR_W  = 16;
    localparam int   BANK_AW = 8;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the LC-3b datapath (master) and mem_ctrl (slave).
interface mem_ctrl_if;
    import lc3b_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/byte_lane_steer.sv
// Combinational lane steering: store data/strobe selection and load merge/sign-extension.
module byte_lane_steer
    import lc3b_mem_pkg::*;
(
    input  logic        i_byte,
    input  logic        i_lane,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_hi_rdata,
    input  logic [7:0]  i_lo_rdata,
    output logic [7:0]  o_hi_wdata,
    output logic [7:0]  o_lo_wdata,
    output logic        o_hi_sel,
    output logic        o_lo_sel,
    output logic [15:0] o_rdata
);

    logic [7:0] w_lane_rdata;

    always_comb begin
        o_hi_sel     = !i_byte || (i_lane == LANE_HI);
        o_lo_sel     = !i_byte || (i_lane != LANE_HI);
        // Byte stores put the byte on both buses; only the strobe picks the lane.
        o_hi_wdata   = i_byte ? i_wdata[7:0] : i_wdata[15:8];
        o_lo_wdata   = i_wdata[7:0];
        w_lane_rdata = (i_lane == LANE_HI) ? i_hi_rdata : i_lo_rdata;
        o_rdata      = i_byte ? {{8{w_lane_rdata[7]}}, w_lane_rdata}
                              : {i_hi_rdata, i_lo_rdata};
    end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3b memory initiator: splits word/byte load/store requests across two 8-bit banks.
module mem_ctrl #(
    parameter int ADDR_W     = lc3b_mem_pkg::ADDR_W,
    parameter int BANK_AW    = lc3b_mem_pkg::BANK_AW,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_ctrl_if.slave          bus,
    output logic [BANK_AW-1:0] mem_addr,
    output logic [7:0]         mem_hi_wdata,
    output logic [7:0]         mem_lo_wdata,
    output logic               mem_hi_write_n,
    output logic               mem_lo_write_n,
    input  logic [7:0]         mem_hi_rdata,
    input  logic [7:0]         mem_lo_rdata
);
    import lc3b_mem_pkg::*;

    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic        r_byte;
    logic        r_lane;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_oor;
    logic        w_byte;
    logic        w_lane;
    logic [7:0]  w_hi_wdata;
    logic [7:0]  w_lo_wdata;
    logic        w_hi_sel;
    logic        w_lo_sel;
    logic [15:0] w_rdata;

    assign w_oor  = |bus.req_addr[ADDR_W-1:BANK_AW+1];
    // Store steering uses the live request in IDLE; load merging uses the latched one.
    assign w_byte = (r_state == IDLE) ? bus.req_byte    : r_byte;
    assign w_lane = (r_state == IDLE) ? bus.req_addr[0] : r_lane;

    byte_lane_steer u_steer (
        .i_byte     (w_byte),
        .i_lane     (w_lane),
        .i_wdata    (bus.req_wdata),
        .i_hi_rdata (mem_hi_rdata),
        .i_lo_rdata (mem_lo_rdata),
        .o_hi_wdata (w_hi_wdata),
        .o_lo_wdata (w_lo_wdata),
        .o_hi_sel   (w_hi_sel),
        .o_lo_sel   (w_lo_sel),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_we           <= 1'b0;
            r_byte         <= 1'b0;
            r_lane         <= 1'b0;
            r_ready        <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            mem_addr       <= '0;
            mem_hi_wdata   <= '0;
            mem_lo_wdata   <= '0;
            mem_hi_write_n <= 1'b1;
            mem_lo_write_n <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        mem_addr <= bus.req_addr[BANK_AW:1];
                        r_we     <= bus.req_we;
                        r_byte   <= bus.req_byte;
                        r_lane   <= bus.req_addr[0];
                        r_ready  <= 1'b0;
                        if (w_oor) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state   <= ACCESS;
                            r_rsp_err <= 1'b0;
                            r_cnt     <= LAT_M1;
                            if (bus.req_we) begin
                                mem_hi_wdata   <= w_hi_wdata;
                                mem_lo_wdata   <= w_lo_wdata;
                                mem_hi_write_n <= !w_hi_sel;
                                mem_lo_write_n <= !w_lo_sel;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        // Strobes were low across exactly one write negedge.
                        mem_hi_write_n <= 1'b1;
                        mem_lo_write_n <= 1'b1;
                        r_rsp_rdata    <= '0;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= RESP;
                    end else if (r_cnt == 3'd0) begin
                        r_rsp_rdata <= w_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: two instances (read latency 1 and 3) against a flat byte-memory model.
module tb_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    mem_ctrl_if if1 ();
    mem_ctrl_if if3 ();

    logic [1:0][7:0] m_addr, m_hwd, m_lwd, m_hrd, m_lrd;
    logic [1:0]      m_hwn, m_lwn;

    mem_ctrl #(.ADDR_W(16), .BANK_AW(8), .RD_LATENCY(1)) u_d1 (
        .clk(clk), .reset(rst1), .bus(if1),
        .mem_addr(m_addr[0]), .mem_hi_wdata(m_hwd[0]), .mem_lo_wdata(m_lwd[0]),
        .mem_hi_write_n(m_hwn[0]), .mem_lo_write_n(m_lwn[0]),
        .mem_hi_rdata(m_hrd[0]), .mem_lo_rdata(m_lrd[0])
    );

    mem_ctrl #(.ADDR_W(16), .BANK_AW(8), .RD_LATENCY(3)) u_d3 (
        .clk(clk), .reset(rst3), .bus(if3),
        .mem_addr(m_addr[1]), .mem_hi_wdata(m_hwd[1]), .mem_lo_wdata(m_lwd[1]),
        .mem_hi_write_n(m_hwn[1]), .mem_lo_write_n(m_lwn[1]),
        .mem_hi_rdata(m_hrd[1]), .mem_lo_rdata(m_lrd[1])
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       sbq [2][$];
    logic [7:0] refm [2][512];
    logic [7:0] bank_hi [2][256];
    logic [7:0] bank_lo [2][256];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_tot = 0;
    int         last_acc [2];
    int         last_off [2];
    bit         held [2];
    logic [1:0] prev_hlow = 2'b00;
    logic [1:0] prev_llow = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] init_byte(input int d, input int a);
        return 8'(a * 29 + 7 + d * 13);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, d, act, exp);
    endtask

    task automatic drive(input int d, input bit v, input bit we, input bit bt,
                         input logic [15:0] a, input logic [15:0] w);
        if (d == 0) begin
            if1.req_valid = v; if1.req_we = we; if1.req_byte = bt;
            if1.req_addr = a;  if1.req_wdata = w;
        end else begin
            if3.req_valid = v; if3.req_we = we; if3.req_byte = bt;
            if3.req_addr = a;  if3.req_wdata = w;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? if1.req_ready : if3.req_ready;
    endfunction
    function automatic logic get_rvalid(input int d);
        return (d == 0) ? if1.rsp_valid : if3.rsp_valid;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? if1.rsp_err : if3.rsp_err;
    endfunction
    function automatic logic [15:0] get_rdata(input int d);
        return (d == 0) ? if1.rsp_rdata : if3.rsp_rdata;
    endfunction
    function automatic logic get_rst(input int d);
        return (d == 0) ? rst1 : rst3;
    endfunction

    // Bank model: write on negedge when strobe is low, read data also updated on negedge.
    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) begin
                bank_hi[d][i] = init_byte(d, 2 * i + 1);
                bank_lo[d][i] = init_byte(d, 2 * i);
            end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m_hwn[d] === 1'b0) bank_hi[d][m_addr[d]] = m_hwd[d];
                if (m_lwn[d] === 1'b0) bank_lo[d][m_addr[d]] = m_lwd[d];
                m_hrd[d] = bank_hi[d][m_addr[d]];
                m_lrd[d] = bank_lo[d][m_addr[d]];
            end
        end
    end

    // Response monitor and strobe-width monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!get_rst(d)) begin
                if (get_rvalid(d) === 1'b1) begin
                    if (sbq[d].size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 at cycle %0d, expected none", d, cyc);
                    end else begin
                        exp_t e;
                        e = sbq[d].pop_front();
                        chk("rsp_rdata", d, 32'(get_rdata(d)), 32'(e.rdata));
                        chk("rsp_err", d, 32'(get_err(d)), 32'(e.err));
                        chk("rsp_cycle", d, 32'(cyc), 32'(e.due));
                        chk("ready_low_in_resp", d, 32'(get_ready(d)), 32'd0);
                    end
                end
                if (m_hwn[d] === 1'b0) chk("hi_strobe_one_cycle", d, 32'(prev_hlow[d]), 32'd0);
                if (m_lwn[d] === 1'b0) chk("lo_strobe_one_cycle", d, 32'(prev_llow[d]), 32'd0);
            end
        end
        prev_hlow <= ~m_hwn;
        prev_llow <= ~m_lwn;
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input int d, input bit we, input bit bt, input logic [15:0] addr,
                         input logic [15:0] wd, input bit hold, input bit track);
        bit         oor, rdy, hs, ls, done;
        logic [8:0] a, alo, ahi;
        exp_t       e;
        int         acc, off, k;
        oor = (addr[15:9] != 7'd0);
        a   = addr[8:0];
        alo = {a[8:1], 1'b0};
        ahi = {a[8:1], 1'b1};
        e.err   = oor;
        e.rdata = 16'h0000;
        if (oor) off = 0;
        else if (we) begin
            off = 1;
            if (bt) refm[d][a] = wd[7:0];
            else begin
                refm[d][ahi] = wd[15:8];
                refm[d][alo] = wd[7:0];
            end
        end else begin
            off = lat(d);
            if (bt) e.rdata = {{8{refm[d][a][7]}}, refm[d][a]};
            else    e.rdata = {refm[d][ahi], refm[d][alo]};
        end
        drive(d, 1'b1, we, bt, addr, wd);
        k = 0;
        done = 0;
        while (!done) begin
            rdy = get_ready(d);
            @(posedge clk);
            #1;
            if (rdy) done = 1;
            else begin
                k++;
                if (k > 50) begin
                    n_tot++;
                    $display("FAIL accept_timeout dut%0d: got no req_ready in 50 cycles, expected acceptance", d);
                    drive(d, 1'b0, we, bt, addr, wd);
                    held[d] = 0;
                    return;
                end
                @(negedge clk);
            end
        end
        acc = cyc;
        if (held[d]) chk("held_accept_gap", d, 32'(acc - last_acc[d]), 32'(last_off[d] + 2));
        last_acc[d] = acc;
        last_off[d] = off;
        held[d]     = hold;
        e.due = acc + off;
        if (track) sbq[d].push_back(e);
        @(negedge clk);
        hs = !oor && we && (!bt || a[0]);
        ls = !oor && we && (!bt || !a[0]);
        chk("mem_addr", d, 32'(m_addr[d]), 32'(a[8:1]));
        chk("hi_write_n", d, 32'(m_hwn[d]), 32'(!hs));
        chk("lo_write_n", d, 32'(m_lwn[d]), 32'(!ls));
        if (we && !oor) begin
            chk("hi_wdata", d, 32'(m_hwd[d]), 32'(bt ? wd[7:0] : wd[15:8]));
            chk("lo_wdata", d, 32'(m_lwd[d]), 32'(wd[7:0]));
        end
        if (!hold) drive(d, 1'b0, we, bt, addr, wd);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 512; i++) refm[d][i] = init_byte(d, i);
            held[d] = 0;
            last_acc[d] = 0;
            last_off[d] = 0;
            drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 32'(get_ready(d)), 32'd1);
            chk("rst_rsp_valid", d, 32'(get_rvalid(d)), 32'd0);
            chk("rst_rsp_err", d, 32'(get_err(d)), 32'd0);
            chk("rst_rsp_rdata", d, 32'(get_rdata(d)), 32'd0);
            chk("rst_mem_addr", d, 32'(m_addr[d]), 32'd0);
            chk("rst_wdata", d, 32'({m_hwd[d], m_lwd[d]}), 32'd0);
            chk("rst_write_n", d, 32'({m_hwn[d], m_lwn[d]}), 32'd3);
        end

        // Directed cases, latency-1 instance.
        issue(0, 1, 0, 16'h0010, 16'h1234, 0, 1);
        issue(0, 0, 0, 16'h0010, 16'h0000, 0, 1);
        issue(0, 1, 1, 16'h0011, 16'h0085, 0, 1);
        issue(0, 0, 1, 16'h0011, 16'h0000, 0, 1);
        issue(0, 0, 0, 16'h0010, 16'h0000, 0, 1);
        issue(0, 0, 0, 16'h0013, 16'h0000, 0, 1);
        issue(0, 0, 0, 16'h0012, 16'h0000, 0, 1);
        issue(0, 0, 0, 16'h0200, 16'h0000, 1, 1);
        issue(0, 1, 0, 16'h0200, 16'hFFFF, 1, 1);
        issue(0, 0, 1, 16'h0010, 16'h0000, 0, 1);

        // Directed cases, latency-3 instance: back-to-back requests held while busy.
        issue(1, 0, 0, 16'h0020, 16'h0000, 1, 1);
        issue(1, 1, 0, 16'h0020, 16'hBEEF, 1, 1);
        issue(1, 0, 1, 16'h0021, 16'h0000, 1, 1);
        issue(1, 0, 0, 16'h0021, 16'h0000, 0, 1);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            int n;
            n = (d == 0) ? 120 : 50;
            for (int i = 0; i < n; i++) begin
                logic [15:0] addr;
                bit hold;
                addr = 16'($urandom_range(0, 511));
                if ($urandom_range(0, 7) == 0) addr[15:9] = 7'($urandom_range(1, 127));
                hold = (i != n - 1) && ($urandom_range(0, 1) == 1);
                issue(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                      16'($urandom), hold, 1);
                if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat (8) @(negedge clk);
        end

        // Reset in the middle of a latency-3 load: no response must follow.
        issue(1, 0, 0, 16'h0044, 16'h0000, 0, 0);
        rst3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", 1, 32'(get_ready(1)), 32'd1);
        chk("midrst_rsp_valid", 1, 32'(get_rvalid(1)), 32'd0);
        chk("midrst_write_n", 1, 32'({m_hwn[1], m_lwn[1]}), 32'd3);
        rst3 = 1'b0;
        held[1] = 0;
        repeat (6) @(negedge clk);
        issue(1, 0, 0, 16'h0044, 16'h0000, 0, 1);

        for (int k = 0; k < 30 && (sbq[0].size() + sbq[1].size()) != 0; k++) @(negedge clk);
        chk("drained_dut0", 0, 32'(sbq[0].size()), 32'd0);
        chk("drained_dut1", 1, 32'(sbq[1].size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Initiator side of the byte-banked main memory.
- Accepts 16-bit word or byte load/store requests from the LC-3b datapath (MAR/MDR path).
- Splits each request onto the high and low 8-bit memory banks. Each bank has an 8-bit address, an active-low write strobe, and is read/written on the negative clock edge.
- Returns read data or a write acknowledge through a one-cycle response pulse.

Parameters:
- ADDR_W, 16, request byte-address width.
- BANK_AW, 8, bank address width (256 entries per bank).
- RD_LATENCY, 1, posedges from acceptance to data capture for reads; legal range 1..7.

Ports:
- clk  in  1  system clock; all controller state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  16  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range; valid with rsp_valid.
- mem_addr  out  8  shared bank address.
- mem_hi_wdata  out  8  high bank write data.
- mem_lo_wdata  out  8  low bank write data.
- mem_hi_write_n  out  1  high bank write strobe, active low.
- mem_lo_write_n  out  1  low bank write strobe, active low.
- mem_hi_rdata  in  8  high bank read data.
- mem_lo_rdata  in  8  low bank read data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - req_ready=1 (state IDLE).
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_addr=0, mem_*_wdata=0, mem_*_write_n=1.
- Address mapping:
  - Bank index is req_addr[8:1].
  - req_addr[0] selects the lane for byte accesses: 1 = high bank, 0 = low bank.
  - For word accesses, req_addr[0] is ignored (forced aligned).
  - Out of range is req_addr[15:9] != 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge N, latch the request and drive mem_addr.
  - In range: go to ACCESS, load the counter with RD_LATENCY-1.
  - Out of range: go straight to RESP with rsp_err=1 and rsp_rdata=0. Neither strobe is asserted.
- ACCESS, store:
  - Strobes are low for exactly one cycle, from edge N to edge N+1, which spans the bank's write negedge.
  - Word store: both strobes low; hi_wdata=wdata[15:8], lo_wdata=wdata[7:0].
  - Byte store: only the selected lane's strobe is low, and wdata[7:0] is driven on both wdata buses.
  - Then go to RESP, regardless of RD_LATENCY.
- ACCESS, load:
  - Strobes stay high.
  - Decrement the counter each edge. At count 0, capture at that edge:
    - word: rsp_rdata={hi,lo};
    - byte: selected lane, sign-extended to 16 bits.
  - Then go to RESP.
  - With RD_LATENCY=1, capture occurs at edge N+1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - rsp_rdata holds its value until the next capture.
  - rsp_err clears on the next accepted request.
- Timing and throughput:
  - Load latency is accept edge N to rsp_valid high after edge N+RD_LATENCY.
  - Store latency is rsp_valid after edge N+1.
  - Maximum throughput is one request per RD_LATENCY+2 cycles.
- req_valid outside IDLE is ignored and must be held by the requester until req_ready is seen.
- Reset mid-operation: return to IDLE on that edge; strobes go high and no response is issued. A store whose strobe was already low before the negedge may have completed; this is not guaranteed.
- Memory bank contents and the banks' own reset are outside this block.

Decomposition:
- Package lc3b_mem_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - ADDR_W and BANK_AW constants;
  - a lane-select helper constant (LANE_HI=1).
- Sub-module byte_lane_steer (combinational): store data/strobe steering and load sign-extension/merge.
- FSM and registers stay in mem_ctrl.

Test Plan:
- Word store 0x1234 to addr 0x0010, then word load from 0x0010:
  - store: mem_addr=0x08, both strobes low for one cycle, rsp_valid 1 cycle later;
  - load: rsp_rdata=0x1234.
- Byte store 0x85 to 0x0011, then byte load from 0x0011:
  - store: only hi strobe low; low bank unchanged;
  - load: rsp_rdata=0xFF85.
- Word load from odd address 0x0013: same data as 0x0012.
- Access to 0x0200: rsp_err=1, rsp_rdata=0, no strobe asserted, rsp_valid after 1 edge.
- RD_LATENCY=3, load: rsp_valid rises 3 edges after acceptance; req_ready low throughout; req_valid held during busy is accepted only on return to IDLE.
- reset asserted during a load's ACCESS: next cycle is IDLE, req_ready=1, no rsp_valid, strobes high.
